// File: rtl/minimips_pkg.sv
// Shared widths, bubble encoding and the fetch-to-decode payload type for the
// minimips front end.
package minimips_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INST_W = 32;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_INST_W-1:0] inst;
    } if_id_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush. in_ready depends only on
// registered state, so backpressure never forms a combinational path upstream.
module pipe_skid_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_v_reg;
    logic [W-1:0] out_data_reg;
    logic         sk_v_reg;
    logic [W-1:0] sk_data_reg;
    logic         acc;

    assign in_ready  = !sk_v_reg;
    assign acc       = in_valid && in_ready;
    assign out_valid = out_v_reg;
    assign out_data  = out_data_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_v_reg    <= 1'b0;
            out_data_reg <= '0;
            sk_v_reg     <= 1'b0;
            sk_data_reg  <= '0;
        end else if (flush) begin
            // Data registers keep stale contents; the valid bits mask them.
            out_v_reg <= 1'b0;
            sk_v_reg  <= 1'b0;
        end else if (!out_v_reg || out_ready) begin
            if (sk_v_reg) begin
                out_v_reg    <= 1'b1;
                out_data_reg <= sk_data_reg;
                sk_v_reg     <= acc;
                if (acc) begin
                    sk_data_reg <= in_data;
                end
            end else begin
                out_v_reg <= acc;
                if (acc) begin
                    out_data_reg <= in_data;
                end
            end
        end else if (acc) begin
            sk_v_reg    <= 1'b1;
            sk_data_reg <= in_data;
        end
    end

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline boundary: skid-buffered {pc, inst} with flush and NOP bubbles.
// Optional stall counter when IF_ID_PERF_EN is defined.
module if_id_skid
    import minimips_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INST_W   = DEF_INST_W,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(DEF_NOP_INST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
`ifdef IF_ID_PERF_EN
    output logic [INST_W-1:0] id_inst,
    output logic [31:0]       perf_stall_cnt
`else
    output logic [INST_W-1:0] id_inst
`endif
);

    localparam int PW = ADDR_W + INST_W;

    logic [PW-1:0] in_payload;
    logic [PW-1:0] out_payload;
    logic          out_v;

    assign in_payload = {if_pc, if_inst};

    pipe_skid_buf #(
        .W(PW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (if_valid),
        .in_ready  (if_ready),
        .in_data   (in_payload),
        .out_valid (out_v),
        .out_ready (id_ready),
        .out_data  (out_payload)
    );

    assign id_valid = out_v;
    assign id_pc    = out_payload[PW-1:INST_W];
    assign id_inst  = out_v ? out_payload[INST_W-1:0] : NOP_INST;

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt_reg;

    // Counts decode-side stalls; deliberately survives flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= 32'd0;
        end else if (out_v && !id_ready) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Directed bench for if_id_skid: reset, streaming, backpressure, flush,
// asynchronous mid-stream reset and (when enabled) the stall counter.
module tb_if_id_skid;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
`ifdef IF_ID_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    int total;
    int bad;

    if_id_skid dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_pc    (id_pc),
`ifdef IF_ID_PERF_EN
        .id_inst  (id_inst),
        .perf_stall_cnt (perf_stall_cnt)
`else
        .id_inst  (id_inst)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] inst, input logic rdy);
        chk({tag, ".id_valid"}, {63'd0, id_valid}, {63'd0, v});
        if (v) chk({tag, ".id_pc"}, {32'd0, id_pc}, {32'd0, pc});
        chk({tag, ".id_inst"}, {32'd0, id_inst}, {32'd0, inst});
        chk({tag, ".if_ready"}, {63'd0, if_ready}, {63'd0, rdy});
        $display("txn %-10s id_valid=%0b id_pc=%h id_inst=%h if_ready=%0b",
                 tag, id_valid, id_pc, id_inst, if_ready);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        flush = 1'b0;
        id_ready = 1'b1;
        drive(1'b1, 32'h100, 32'hdead_beef);
        #1;
        chk_out("rst0", 1'b0, 32'h0, 32'h0, 1'b1);
        chk("rst0.id_pc", {32'd0, id_pc}, 64'd0);
        step();
        step();
        chk_out("rst2", 1'b0, 32'h0, 32'h0, 1'b1);

        // Release reset and stream three instructions.
        rst = 1'b1;
        drive(1'b1, 32'h0, 32'h3401_1100);
        step();
        chk_out("s0", 1'b1, 32'h0, 32'h3401_1100, 1'b1);
        drive(1'b1, 32'h4, 32'h3402_0020);
        step();
        chk_out("s1", 1'b1, 32'h4, 32'h3402_0020, 1'b1);
        drive(1'b1, 32'h8, 32'h3403_ff00);
        step();
        chk_out("s2", 1'b1, 32'h8, 32'h3403_ff00, 1'b1);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk_out("s_idle", 1'b0, 32'h0, 32'h0, 1'b1);

        // Backpressure: three cycles with id_ready low.
        id_ready = 1'b0;
        drive(1'b1, 32'h10, 32'h1111_0010);
        step();
        chk_out("bp0", 1'b1, 32'h10, 32'h1111_0010, 1'b1);
        drive(1'b1, 32'h14, 32'h1111_0014);
        step();
        chk_out("bp1", 1'b1, 32'h10, 32'h1111_0010, 1'b0);
        drive(1'b1, 32'h18, 32'h1111_0018);
        step();
        chk_out("bp2", 1'b1, 32'h10, 32'h1111_0010, 1'b0);
        id_ready = 1'b1;
        step();
        chk_out("bp3", 1'b1, 32'h14, 32'h1111_0014, 1'b1);
        step();
        chk_out("bp4", 1'b1, 32'h18, 32'h1111_0018, 1'b1);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk_out("bp5", 1'b0, 32'h0, 32'h0, 1'b1);
`ifdef IF_ID_PERF_EN
        chk("perf_bp", {32'd0, perf_stall_cnt}, 64'd2);
`endif

        // Flush with both entries full; offered 0x20 must vanish.
        id_ready = 1'b0;
        drive(1'b1, 32'h40, 32'h2222_0040);
        step();
        drive(1'b1, 32'h44, 32'h2222_0044);
        step();
        chk_out("fl_full", 1'b1, 32'h40, 32'h2222_0040, 1'b0);
        flush    = 1'b1;
        id_ready = 1'b1;
        drive(1'b1, 32'h20, 32'h2222_0020);
        step();
        chk_out("fl0", 1'b0, 32'h0, 32'h0, 1'b1);
`ifdef IF_ID_PERF_EN
        chk("perf_flush", {32'd0, perf_stall_cnt}, 64'd3);
`endif
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk_out("fl1", 1'b0, 32'h0, 32'h0, 1'b1);
        step();
        chk_out("fl2", 1'b0, 32'h0, 32'h0, 1'b1);

        // One entry loaded, then five pure stall cycles.
        id_ready = 1'b0;
        drive(1'b1, 32'h60, 32'h3333_0060);
        step();
        drive(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) step();
        chk_out("stall5", 1'b1, 32'h60, 32'h3333_0060, 1'b1);
`ifdef IF_ID_PERF_EN
        chk("perf_stall5", {32'd0, perf_stall_cnt}, 64'd8);
`endif

        // Fill the skid, then assert reset between clock edges.
        drive(1'b1, 32'h64, 32'h3333_0064);
        step();
        chk_out("ar_full", 1'b1, 32'h60, 32'h3333_0060, 1'b0);
        drive(1'b0, 32'h0, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        chk_out("ar_now", 1'b0, 32'h0, 32'h0, 1'b1);
        chk("ar_now.id_pc", {32'd0, id_pc}, 64'd0);
`ifdef IF_ID_PERF_EN
        chk("perf_rst", {32'd0, perf_stall_cnt}, 64'd0);
`endif
        step();
        rst = 1'b1;
        id_ready = 1'b1;
        step();
        chk_out("ar_after", 1'b0, 32'h0, 32'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
- IF/ID pipeline boundary between the instruction fetch stage (pc_reg plus instruction ROM) and the decode stage.
- Registers {pc, inst} from fetch with a valid/ready handshake.
- A 2-entry skid buffer keeps fetch backpressure fully registered.
- Synchronous flush squashes in-flight instructions on branch redirect; the decode stage sees a NOP bubble (inst = 0) whenever nothing valid is presented.

Parameters:
- ADDR_W, 32, PC width in bits
- INST_W, 32, instruction width in bits
- NOP_INST, 32'h0000_0000, value driven on id_inst when id_valid = 0

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  squash all buffered instructions, synchronous, highest priority
- if_valid  in  1  fetch presents a valid instruction
- if_ready  out  1  buffer can accept this cycle
- if_pc  in  ADDR_W  PC of the fetched instruction
- if_inst  in  INST_W  fetched instruction word
- id_valid  out  1  decode-side valid
- id_ready  in  1  decode accepts this cycle
- id_pc  out  ADDR_W  PC presented to decode
- id_inst  out  INST_W  instruction presented to decode; NOP_INST when id_valid = 0

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-low on port rst.
- State:
  - Output register: out_v, out_pc, out_inst.
  - Skid register: sk_v, sk_pc, sk_inst.
- Reset (rst = 0, takes effect immediately without a clock edge):
  - out_v = 0, sk_v = 0, all pc/inst registers = 0.
  - Hence id_valid = 0, id_pc = 0, id_inst = NOP_INST, if_ready = 1.
- Handshake signals:
  - if_ready = !sk_v, a registered term with no combinational path from id_ready.
  - Input accept: acc = if_valid & if_ready.
  - Output transfer: xfer = id_valid & id_ready.
- Outputs: id_valid = out_v; id_pc = out_pc; id_inst = out_v ? out_inst : NOP_INST.
- Update rules (priority order):
  1. flush = 1: out_v <= 0, sk_v <= 0. Input offered that cycle is discarded even if if_valid = 1. if_ready is 1 from the next cycle.
  2. Output slot free (out_v = 0 or id_ready = 1):
     - if sk_v, out <= sk, and the skid takes the input if acc (sk_v <= acc);
     - else out <= input with out_v <= acc.
  3. Output slot held (out_v = 1, id_ready = 0): if acc, sk <= input and sk_v <= 1.
- Latency and throughput:
  - Latency is 1 cycle from acc to id_valid.
  - Full throughput is 1 instruction/cycle while id_ready = 1.
- Ordering: strict FIFO order with no loss and no duplication. sk_v = 1 implies out_v = 1; the state sk_v & !out_v must never occur.
- Full condition: sk_v = 1 drives if_ready = 0. Fetch must hold pc/inst stable while if_valid & !if_ready.
- Simultaneous pop and push with both entries full: out <= sk, sk cleared, input not accepted because if_ready = 0.
- pc/inst registers load only on accept or move. Values are not cleared on flush; they are masked by the valid bits.
- Reset asserted mid-stream: all buffered entries are lost and state returns to reset values immediately.

Optional Feature:
- Macro: IF_ID_PERF_EN.
- With the macro defined:
  - Adds output port perf_stall_cnt (32 bits).
  - Counts cycles with out_v & !id_ready; wraps modulo 2^32.
  - Reset value is 0; the counter is not cleared by flush.
- Without the macro: the port and the counter are absent, and all other behaviour is identical.

Decomposition:
- Package minimips_pkg holds ADDR_W/INST_W defaults, NOP_INST, and typedef if_id_payload_t (struct: pc, inst).
- One natural sub-module: pipe_skid_buf, a generic 2-entry valid/ready skid buffer parameterised on payload width with a flush input.
- if_id_skid instantiates pipe_skid_buf and adds the NOP masking and the optional perf counter.

Test Plan:
- Reset behaviour: hold rst = 0 for 2 cycles with if_valid = 1 -> id_valid = 0, id_inst = 0, if_ready = 1. Release rst -> first input appears on the output 1 cycle later.
- Streaming: id_ready = 1; feed pc = 0x0, 0x4, 0x8 with inst 0x34011100, 0x34020020, 0x3403ff00 -> same sequence on id_* 1 cycle later, one per cycle, no bubbles.
- Backpressure: drop id_ready for 3 cycles while feeding pc = 0x10, 0x14, 0x18 -> if_ready falls after the 2nd accept and 0x18 is held upstream. On id_ready = 1, the output order is 0x10, 0x14, 0x18 exactly once each.
- Flush with both entries full: skid full plus flush = 1 with if_valid = 1 (pc = 0x20) -> next cycle id_valid = 0, id_inst = 0, if_ready = 1, and 0x20 never appears.
- Asynchronous reset mid-operation: assert rst = 0 between clock edges with both entries full -> id_valid drops immediately without a clock edge, and if_ready = 1.
- Perf counter (IF_ID_PERF_EN): 5 cycles of id_valid & !id_ready -> perf_stall_cnt = 5. Flush -> value retained.
